// File: rtl/mode1_max_reduce_if.sv
// Beat/result bus of the softmax mode-1 max-reduction stage.
// The nan_flag signal exists only when MODE1_MAX_NAN_FLAG_EN is defined.
interface mode1_max_reduce_if #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DATAWIDTH = 16
);
  logic                 start;
  logic [CNT_W-1:0]     num_beats;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] inp0;
  logic [DATAWIDTH-1:0] inp1;
  logic [DATAWIDTH-1:0] inp2;
  logic [DATAWIDTH-1:0] inp3;
  logic [DATAWIDTH-1:0] inp4;
  logic [DATAWIDTH-1:0] inp5;
  logic [DATAWIDTH-1:0] inp6;
  logic [DATAWIDTH-1:0] inp7;
  logic [DATAWIDTH-1:0] max_outp;
  logic                 max_valid;
  logic                 busy;

`ifdef MODE1_MAX_NAN_FLAG_EN
  logic                 nan_flag;

  modport master (
    output start, num_beats, in_valid,
    output inp0, inp1, inp2, inp3, inp4, inp5, inp6, inp7,
    input  in_ready, max_outp, max_valid, busy, nan_flag
  );

  modport slave (
    input  start, num_beats, in_valid,
    input  inp0, inp1, inp2, inp3, inp4, inp5, inp6, inp7,
    output in_ready, max_outp, max_valid, busy, nan_flag
  );
`else
  modport master (
    output start, num_beats, in_valid,
    output inp0, inp1, inp2, inp3, inp4, inp5, inp6, inp7,
    input  in_ready, max_outp, max_valid, busy
  );

  modport slave (
    input  start, num_beats, in_valid,
    input  inp0, inp1, inp2, inp3, inp4, inp5, inp6, inp7,
    output in_ready, max_outp, max_valid, busy
  );
`endif
endinterface

// File: rtl/mode1_max_reduce.sv
// Streaming 8-lane running-max reduction feeding the softmax mode-2 subtract.
// Optional sticky NaN indicator enabled by MODE1_MAX_NAN_FLAG_EN.
module mode1_max_reduce #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned MANTISSA  = 10,
  parameter int unsigned EXPONENT  = 5
) (
  input logic               clk,
  input logic               reset,
  mode1_max_reduce_if.slave bus
);

  localparam int unsigned LANES = 8;
  localparam logic [DATAWIDTH-1:0] NEG_INF =
    DATAWIDTH'({1'b1, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}});

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t               state;
  state_t               next_state;
  logic                 start_acc;
  logic                 beat_acc;
  logic [CNT_W-1:0]     cnt;
  logic                 s1_valid;
  logic [DATAWIDTH-1:0] chunk_q;
  logic [DATAWIDTH-1:0] chunk_c;
  logic [DATAWIDTH-1:0] running;
  logic [DATAWIDTH-1:0] lane [LANES];
  logic [DATAWIDTH-1:0] lvl1 [4];
  logic [DATAWIDTH-1:0] lvl2 [2];

  function automatic logic is_nan(input logic [DATAWIDTH-1:0] x);
    return (&x[DATAWIDTH-2:MANTISSA]) && (|x[MANTISSA-1:0]);
  endfunction

  // Signed ordering key: both zeros map to 0, negatives ordered by magnitude.
  function automatic logic signed [DATAWIDTH-1:0] ord_key(input logic [DATAWIDTH-1:0] x);
    logic [DATAWIDTH-1:0] mag;
    mag = {1'b0, x[DATAWIDTH-2:0]};
    return x[DATAWIDTH-1] ? -$signed(mag) : $signed(mag);
  endfunction

  // Strictly-greater; a NaN is below everything, including another NaN.
  function automatic logic gt(input logic [DATAWIDTH-1:0] a, input logic [DATAWIDTH-1:0] b);
    if (is_nan(a)) return 1'b0;
    if (is_nan(b)) return 1'b1;
    return ord_key(a) > ord_key(b);
  endfunction

  // The incumbent survives ties, so lower lanes and the running max win.
  function automatic logic [DATAWIDTH-1:0] max2(input logic [DATAWIDTH-1:0] keep,
                                                input logic [DATAWIDTH-1:0] cand);
    return gt(cand, keep) ? cand : keep;
  endfunction

  always_comb begin
    lane[0] = bus.inp0;
    lane[1] = bus.inp1;
    lane[2] = bus.inp2;
    lane[3] = bus.inp3;
    lane[4] = bus.inp4;
    lane[5] = bus.inp5;
    lane[6] = bus.inp6;
    lane[7] = bus.inp7;
  end

  // 8-to-1 comparator tree over the presented beat.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl1[i] = max2(lane[2*i], lane[2*i+1]);
    end
    lvl2[0] = max2(lvl1[0], lvl1[1]);
    lvl2[1] = max2(lvl1[2], lvl1[3]);
    chunk_c = max2(lvl2[0], lvl2[1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_acc  = 1'b0;
    beat_acc   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          start_acc  = 1'b1;
          next_state = (bus.num_beats == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          beat_acc = 1'b1;
          if (cnt == CNT_W'(1)) next_state = DRAIN;
        end
      end
      DRAIN:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Stage 1 registers the chunk max, stage 2 folds it into the running max.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
      chunk_q  <= '0;
      running  <= '0;
    end else begin
      s1_valid <= beat_acc;
      if (beat_acc) chunk_q <= chunk_c;
      if (s1_valid) running <= max2(running, chunk_q);
      if (start_acc) begin
        cnt     <= bus.num_beats;
        running <= NEG_INF;
      end else if (beat_acc) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // busy stays up through the cycle that carries the max_valid pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.in_ready  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.max_valid <= 1'b0;
      bus.max_outp  <= '0;
    end else begin
      bus.in_ready  <= (next_state == ACCUM);
      bus.busy      <= (next_state != IDLE) || (state == DONE);
      bus.max_valid <= (state == DONE);
      if (state == DONE) bus.max_outp <= running;
    end
  end

`ifdef MODE1_MAX_NAN_FLAG_EN
  logic beat_nan;
  logic nan_acc;

  always_comb begin
    beat_nan = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      beat_nan = beat_nan | is_nan(lane[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nan_acc      <= 1'b0;
      bus.nan_flag <= 1'b0;
    end else begin
      if (start_acc)                 nan_acc <= 1'b0;
      else if (beat_acc && beat_nan) nan_acc <= 1'b1;
      if (state == DONE) bus.nan_flag <= nan_acc;
    end
  end
`endif

endmodule

// File: tb/tb_mode1_max_reduce.sv
// Directed self-checking bench for mode1_max_reduce (fp16 default build).
module tb_mode1_max_reduce;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   n;

  mode1_max_reduce_if #(.CNT_W(8), .DATAWIDTH(16)) bus ();

  mode1_max_reduce dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lane 0 in the top 16 bits.
  task automatic set_lanes(input logic [127:0] v);
    bus.inp0 = v[127:112];
    bus.inp1 = v[111:96];
    bus.inp2 = v[95:80];
    bus.inp3 = v[79:64];
    bus.inp4 = v[63:48];
    bus.inp5 = v[47:32];
    bus.inp6 = v[31:16];
    bus.inp7 = v[15:0];
  endtask

  task automatic begin_vec(input logic [7:0] beats);
    bus.start     = 1'b1;
    bus.num_beats = beats;
    step();
    bus.start     = 1'b0;
  endtask

  task automatic beat(input logic [127:0] v);
    set_lanes(v);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int steps);
    steps = 0;
    do begin
      step();
      steps++;
    end while (bus.max_valid !== 1'b1 && steps < 20);
    check({tag, " valid"}, 32'(bus.max_valid), 32'd1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.num_beats = '0;
    bus.in_valid  = 1'b0;
    set_lanes('0);
    #12;
    check("rst in_ready", 32'(bus.in_ready), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst max_valid", 32'(bus.max_valid), 32'd0);
    check("rst max_outp", 32'(bus.max_outp), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Single beat: latency and busy envelope.
    begin_vec(8'd1);
    check("t1 busy start", 32'(bus.busy), 32'd1);
    check("t1 in_ready", 32'(bus.in_ready), 32'd1);
    set_lanes({16'h3C00, 16'h4000, 16'hBC00, 16'h0000, 16'h3800, 16'hC000, 16'h3E00, 16'h3A00});
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("t1 ready drop", 32'(bus.in_ready), 32'd0);
    check("t1 busy drain", 32'(bus.busy), 32'd1);
    wait_valid("t1", n);
    check("t1 latency", 32'(n + 1), 32'd3);
    check("t1 max", 32'(bus.max_outp), 32'h4000);
    check("t1 busy valid", 32'(bus.busy), 32'd1);
    step();
    check("t1 pulse", 32'(bus.max_valid), 32'd0);
    check("t1 busy idle", 32'(bus.busy), 32'd0);
    check("t1 hold", 32'(bus.max_outp), 32'h4000);

    // Four back-to-back beats.
    begin_vec(8'd4);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("t2 ready b%0d", b), 32'(bus.in_ready), 32'd1);
      set_lanes({16'h3C00, 16'h4000, 16'hBC00, 16'h0000, 16'h3800,
                 (b == 2) ? 16'h7BFF : 16'h3A00, 16'hC000, 16'h3E00});
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    check("t2 ready drop", 32'(bus.in_ready), 32'd0);
    wait_valid("t2", n);
    check("t2 max", 32'(bus.max_outp), 32'h7BFF);

    // All-negative vector.
    begin_vec(8'd2);
    bus.in_valid = 1'b1;
    set_lanes({16'hFC00, 16'hF000, 16'hC000, 16'hBC00, 16'hC200, 16'hD000, 16'hE000, 16'hFBFF});
    step();
    beat({16'hC400, 16'hBE00, 16'hFC00, 16'hBD00, 16'hC800, 16'hCC00, 16'hD400, 16'hF800});
    wait_valid("t3", n);
    check("t3 max", 32'(bus.max_outp), 32'hBC00);

    // Zero-length vector.
    begin_vec(8'd0);
    check("t3z busy", 32'(bus.busy), 32'd1);
    check("t3z no valid", 32'(bus.max_valid), 32'd0);
    wait_valid("t3z", n);
    check("t3z latency", 32'(n), 32'd1);
    check("t3z max", 32'(bus.max_outp), 32'hFC00);

    // Signed-zero tie.
    begin_vec(8'd1);
    beat({16'h8000, 16'h8000, 16'h0000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000});
    wait_valid("t4", n);
    check("t4 tie", 32'(bus.max_outp), 32'h8000);
`ifdef MODE1_MAX_NAN_FLAG_EN
    check("t4 nan_flag", 32'(bus.nan_flag), 32'd0);
`endif

    // NaN never wins.
    begin_vec(8'd1);
    beat({16'h0000, 16'h7E00, 16'hBC00, 16'h0000, 16'h3C00, 16'h3800, 16'hFC00, 16'h0000});
    wait_valid("t4n", n);
    check("t4n max", 32'(bus.max_outp), 32'h3C00);
`ifdef MODE1_MAX_NAN_FLAG_EN
    check("t4n nan_flag", 32'(bus.nan_flag), 32'd1);
`endif

    // Stalled stream: +inf on idle cycles must be ignored.
    begin_vec(8'd3);
    beat({16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4200});
    set_lanes({8{16'h7C00}});
    step();
    check("t5 ready gap1", 32'(bus.in_ready), 32'd1);
    beat({16'h4400, 16'h3800, 16'hC000, 16'h3C00, 16'h0000, 16'h3400, 16'h3000, 16'h3C00});
    set_lanes({8{16'h7C00}});
    step();
    check("t5 ready gap2", 32'(bus.in_ready), 32'd1);
    beat({16'h3E00, 16'h3800, 16'h3800, 16'h3800, 16'h3800, 16'h3800, 16'h3800, 16'h3800});
    check("t5 ready drop", 32'(bus.in_ready), 32'd0);
    wait_valid("t5", n);
    check("t5 max", 32'(bus.max_outp), 32'h4400);

    // Reset in the middle of a reduction.
    begin_vec(8'd3);
    beat({8{16'h5000}});
    check("t6 ready mid", 32'(bus.in_ready), 32'd1);
    reset = 1'b1;
    #2;
    check("t6 rst in_ready", 32'(bus.in_ready), 32'd0);
    check("t6 rst busy", 32'(bus.busy), 32'd0);
    check("t6 rst max_valid", 32'(bus.max_valid), 32'd0);
    check("t6 rst max_outp", 32'(bus.max_outp), 32'd0);
    step();
    @(negedge clk);
    reset = 1'b0;
    step();

    // Fresh start after reset; a start pulse during ACCUM is ignored.
    begin_vec(8'd1);
    set_lanes({16'h3800, 16'h3400, 16'hB800, 16'h0000, 16'h3000, 16'h2C00, 16'hC000, 16'h3400});
    bus.start     = 1'b1;
    bus.num_beats = 8'd5;
    bus.in_valid  = 1'b1;
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    wait_valid("t7", n);
    check("t7 latency", 32'(n + 1), 32'd3);
    check("t7 max", 32'(bus.max_outp), 32'h3800);
    step();
    check("t7 busy idle", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
